// File: rtl/acc_sequencer.sv
// Accumulator and operation sequencer driving an external N-bit add/subtract stage.
// Performs LOAD/ADD/SUB in place and MUL as an N-step shift-add loop through the same adder.
module acc_sequencer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [1:0]   op_code,
   input  logic [N-1:0] op_data,
   output logic [N-1:0] add_x,
   output logic [N-1:0] add_y,
   output logic         add_sub,
   input  logic [N-1:0] add_sum,
   input  logic         add_cout,
   output logic [N-1:0] acc,
   output logic         flag_c,
   output logic         flag_z,
   output logic         flag_v,
   output logic         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_MUL  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL
   } state_t;

   state_t         state;
   state_t         state_next;
   op_t            op_reg;
   logic [N-1:0]   b_reg;
   logic [N-1:0]   m_reg;
   logic [N-1:0]   p_reg;
   logic [N-1:0]   q_reg;
   logic [CW-1:0]  count;

   logic           accept;
   logic           mul_last;
   logic           ovf_add;
   logic           ovf_sub;
   logic [N-1:0]   final_p;
   logic [N-1:0]   final_q;

   assign accept   = op_valid & op_ready;
   assign mul_last = (count == CW'(N - 1));

   // Product halves as they will look after the current shift-add step
   assign final_q  = {add_sum[0], q_reg[N-1:1]};
   assign final_p  = {add_cout, add_sum[N-1:1]};

   assign ovf_add  = (acc[N-1] == b_reg[N-1]) & (add_sum[N-1] != acc[N-1]);
   assign ovf_sub  = (acc[N-1] != b_reg[N-1]) & (add_sum[N-1] != acc[N-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Adder inputs depend on registered state only, never on op_* inputs
   always_comb begin
      state_next = state;
      op_ready   = 1'b0;
      add_x      = acc;
      add_y      = '0;
      add_sub    = 1'b0;
      case (state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               case (op_t'(op_code))
                  OP_ADD, OP_SUB: state_next = S_EXEC;
                  OP_MUL:         state_next = S_MUL;
                  default:        state_next = S_IDLE;
               endcase
            end
         end
         S_EXEC: begin
            add_y      = b_reg;
            add_sub    = (op_reg == OP_SUB);
            state_next = S_IDLE;
         end
         S_MUL: begin
            add_x = p_reg;
            add_y = q_reg[0] ? m_reg : '0;
            if (mul_last) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg <= OP_LOAD;
         b_reg  <= '0;
         m_reg  <= '0;
         p_reg  <= '0;
         q_reg  <= '0;
         count  <= '0;
         acc    <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_v <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_reg <= op_t'(op_code);
                  b_reg  <= op_data;
                  case (op_t'(op_code))
                     OP_LOAD: begin
                        acc    <= op_data;
                        flag_z <= (op_data == '0);
                        flag_c <= 1'b0;
                        flag_v <= 1'b0;
                        done   <= 1'b1;
                     end
                     OP_MUL: begin
                        m_reg <= acc;
                        q_reg <= op_data;
                        p_reg <= '0;
                        count <= '0;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            S_EXEC: begin
               acc    <= add_sum;
               flag_c <= add_cout;
               flag_z <= (add_sum == '0);
               flag_v <= (op_reg == OP_SUB) ? ovf_sub : ovf_add;
               done   <= 1'b1;
            end
            S_MUL: begin
               {p_reg, q_reg} <= {add_cout, add_sum, q_reg[N-1:1]};
               count          <= count + CW'(1);
               if (mul_last) begin
                  acc    <= final_q;
                  flag_c <= |final_p;
                  flag_z <= (final_q == '0);
                  flag_v <= 1'b0;
                  done   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: directed ops push expected results, a done-driven monitor checks them.
// A behavioural adder closes the loop between add_x/add_y/add_sub and add_sum/add_cout.
module tb_acc_sequencer;

   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] ADD  = 2'b01;
   localparam logic [1:0] SUB  = 2'b10;
   localparam logic [1:0] MUL  = 2'b11;

   logic       clk;
   logic       rst_n;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] op_code;
   logic [3:0] op_data;
   logic [3:0] add_x;
   logic [3:0] add_y;
   logic       add_sub;
   logic [3:0] add_sum;
   logic       add_cout;
   logic [3:0] acc;
   logic       flag_c;
   logic       flag_z;
   logic       flag_v;
   logic       done;

   int total = 0;
   int bad = 0;
   int done_seen = 0;

   logic [6:0] exp_q[$];
   string      name_q[$];

   acc_sequencer #(.N(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_data  (op_data),
      .add_x    (add_x),
      .add_y    (add_y),
      .add_sub  (add_sub),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .acc      (acc),
      .flag_c   (flag_c),
      .flag_z   (flag_z),
      .flag_v   (flag_v),
      .done     (done)
   );

   // Subtraction is X + ~Y + 1, so carry-out means "no borrow"
   assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)} + {4'b0, add_sub};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " acc"},      {4'b0, acc}, 8'h00);
      checkOutput({tag, " flags"},    {5'b0, flag_c, flag_z, flag_v}, 8'h00);
      checkOutput({tag, " op_ready"}, {7'b0, op_ready}, 8'h01);
      checkOutput({tag, " done"},     {7'b0, done}, 8'h00);
      checkOutput({tag, " add_x"},    {4'b0, add_x}, 8'h00);
      checkOutput({tag, " add_y"},    {4'b0, add_y}, 8'h00);
      checkOutput({tag, " add_sub"},  {7'b0, add_sub}, 8'h00);
   endtask

   // Issue one op and return 1 time unit after its accept edge
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                                input logic [3:0] e_acc, input logic e_c, input logic e_z,
                                input logic e_v, input bit expect_done, input string name);
      int n;
      if (expect_done) begin
         exp_q.push_back({e_acc, e_c, e_z, e_v});
         name_q.push_back(name);
      end
      op_valid = 1'b1;
      op_code  = op;
      op_data  = data;
      n = 0;
      while (!op_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!op_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL %s accept timeout: op_ready=%0b required 1", name, op_ready);
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic countBusy(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!op_ready && n < 20);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL spurious done: acc=%h with no operation pending", acc);
         end else begin
            checkOutput(name_q.pop_front(), {1'b0, acc, flag_c, flag_z, flag_v}, {1'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      int busy;
      int accepts;
      int seen_before;
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op_code  = LOAD;
      op_data  = 4'h0;
      #2;
      checkResetState("power-on reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(LOAD, 4'h5, 4'h5, 0, 0, 0, 1, "load 5");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkResetState("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(LOAD, 4'h5, 4'h5, 0, 0, 0, 1, "reload 5");
      applyStimulus(ADD,  4'h3, 4'h8, 0, 0, 1, 1, "5 add 3");
      countBusy(busy);
      checkOutput("add busy cycles", 8'(busy), 8'd1);
      applyStimulus(LOAD, 4'h9, 4'h9, 0, 0, 0, 1, "load 9");
      applyStimulus(ADD,  4'h7, 4'h0, 1, 1, 0, 1, "9 add 7");
      applyStimulus(LOAD, 4'h3, 4'h3, 0, 0, 0, 1, "load 3");
      applyStimulus(SUB,  4'h5, 4'hE, 0, 0, 0, 1, "3 sub 5");
      applyStimulus(LOAD, 4'h5, 4'h5, 0, 0, 0, 1, "load 5b");
      applyStimulus(SUB,  4'h5, 4'h0, 1, 1, 0, 1, "5 sub 5");

      applyStimulus(LOAD, 4'h7, 4'h7, 0, 0, 0, 1, "load 7");
      applyStimulus(MUL,  4'h3, 4'h5, 1, 0, 0, 1, "7 mul 3");
      countBusy(busy);
      checkOutput("mul busy cycles", 8'(busy), 8'd4);
      applyStimulus(LOAD, 4'h3, 4'h3, 0, 0, 0, 1, "load 3b");
      applyStimulus(MUL,  4'h5, 4'hF, 0, 0, 0, 1, "3 mul 5");
      applyStimulus(LOAD, 4'h0, 4'h0, 0, 1, 0, 1, "load 0");
      applyStimulus(MUL,  4'h9, 4'h0, 0, 1, 0, 1, "0 mul 9");

      // Continuous ADD request: one accept every two cycles
      applyStimulus(LOAD, 4'h1, 4'h1, 0, 0, 0, 1, "load 1");
      for (int k = 2; k <= 5; k++) begin
         exp_q.push_back({4'(k), 3'b000});
         name_q.push_back($sformatf("held add to %0d", k));
      end
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = ADD;
      op_data  = 4'h1;
      accepts  = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (op_ready) accepts++;
      end
      op_valid = 1'b0;
      checkOutput("held add accepts", 8'(accepts), 8'd4);

      // Request held during MUL must wait and leave acc untouched
      applyStimulus(LOAD, 4'h2, 4'h2, 0, 0, 0, 1, "load 2");
      applyStimulus(MUL,  4'h3, 4'h6, 0, 0, 0, 1, "2 mul 3");
      op_valid = 1'b1;
      op_code  = LOAD;
      op_data  = 4'hF;
      busy = 0;
      while (!op_ready && busy < 20) begin
         checkOutput("acc held during mul", {4'b0, acc}, 8'h02);
         @(negedge clk);
         busy++;
      end
      applyStimulus(LOAD, 4'hF, 4'hF, 0, 0, 0, 1, "load F after mul");

      // Abort a MUL in its third iteration
      applyStimulus(LOAD, 4'h7, 4'h7, 0, 0, 0, 1, "load 7b");
      applyStimulus(MUL,  4'h3, 4'h0, 0, 0, 0, 0, "aborted mul");
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkResetState("mid-mul reset");
      seen_before = done_seen;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("no done after abort", 8'(done_seen - seen_before), 8'd0);

      applyStimulus(LOAD, 4'hA, 4'hA, 0, 0, 0, 1, "load A after abort");
      applyStimulus(ADD,  4'h6, 4'h0, 1, 1, 0, 1, "A add 6");
      repeat (4) @(negedge clk);
      checkOutput("scoreboard drained", 8'(exp_q.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
